// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Parametrised serial pattern detector. One serial bit is sampled on each
// rising CP edge where Sin_en=1. When the last N sampled bits equal the
// active pattern, a one-cycle registered pulse is produced on Out and the
// saturating match counter advances. The pattern comes from PATTERN at reset
// and can be replaced at run time through Pat_load/Pat_in.
//
// Parameters
//   N        pattern length in bits (2..32)
//   PATTERN  reset-time pattern, PATTERN[N-1] is the first bit received
//   OVERLAP  1: overlapping matches allowed, 0: window restarts after a match
//   CNT_W    width of the match counter
//
// Ports
//   CP        in   clock, rising edge
//   nCR       in   asynchronous active-low reset
//   Sin       in   serial data bit
//   Sin_en    in   qualifies Sin
//   Pat_load  in   load Pat_in as the active pattern (wins over Sin_en)
//   Pat_in    in   N-bit run-time pattern, bit N-1 received first
//   Cnt_clr   in   synchronous clear of Match_cnt
//   Out       out  registered match pulse, one cycle per match
//   Match_cnt out  saturating match count
//   Armed     out  N-1 valid bits held; the next valid bit can complete a match
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b0101,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = 8
) (
    input  logic             CP,
    input  logic             nCR,
    input  logic             Sin,
    input  logic             Sin_en,
    input  logic             Pat_load,
    input  logic [N-1:0]     Pat_in,
    input  logic             Cnt_clr,
    output logic             Out,
    output logic [CNT_W-1:0] Match_cnt,
    output logic             Armed
);

    // fill counts 0..N-1
    localparam int             FW       = $clog2(N);
    localparam logic [FW-1:0]  FILL_MAX = FW'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [N-1:0]     pat_reg, pat_next;
    logic [N-2:0]     hist_reg, hist_next;
    logic [FW-1:0]    fill_reg, fill_next;
    logic             out_reg, out_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [N-2:0]     hist_shift;
    logic [N-1:0]     win;
    logic             sample;
    logic             match;

    // History shifted by one with the current bit entering at the LSB.
    // Built bitwise so that N=2 (a one-bit history) needs no special case.
    assign hist_shift[0] = Sin;
    generate
        for (genvar gi = 1; gi < N - 1; gi++) begin : g_hist_shift
            assign hist_shift[gi] = hist_reg[gi-1];
        end
    endgenerate

    assign win    = {hist_reg, Sin};
    assign sample = Sin_en && !Pat_load;
    assign match  = sample && (state_reg == ST_ARMED) && (win == pat_reg);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state_reg <= ST_FILL;
            pat_reg   <= PATTERN;
            hist_reg  <= '0;
            fill_reg  <= '0;
            out_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pat_reg   <= pat_next;
            hist_reg  <= hist_next;
            fill_reg  <= fill_next;
            out_reg   <= out_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pat_next  = pat_reg;
        hist_next = hist_reg;
        fill_next = fill_reg;
        out_next  = 1'b0;        // Out is never stretched past one cycle
        cnt_next  = cnt_reg;

        if (Pat_load) begin
            // Sin is ignored on the load edge; stale history is harmless
            // because fill restarts and gates any match.
            pat_next  = Pat_in;
            fill_next = '0;
        end else if (Sin_en) begin
            hist_next = hist_shift;
            out_next  = match;
            if (match && !OVERLAP) begin
                fill_next = '0;
            end else if (fill_reg != FILL_MAX) begin
                fill_next = fill_reg + FW'(1);
            end
        end

        // A clear coinciding with a match counts that match.
        if (match) begin
            if (Cnt_clr) begin
                cnt_next = CNT_W'(1);
            end else if (cnt_reg != CNT_MAX) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end else if (Cnt_clr) begin
            cnt_next = '0;
        end

        state_next = (fill_next == FILL_MAX) ? ST_ARMED : ST_FILL;
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    always_comb begin
        Armed     = (state_reg == ST_ARMED);
        Out       = out_reg;
        Match_cnt = cnt_reg;
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// Testbench for seq_detect_param. Three instances share the stimulus:
//   A: N=4, 0101, overlapping,     8-bit counter
//   B: N=4, 0101, non-overlapping, 8-bit counter
//   C: N=4, 1111, overlapping,     2-bit counter
// Each stimulus step pushes the hand-computed expected response of one
// instance; a monitor pops and compares after every clock edge or reset fall.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       nCR = 1'b0;
    logic       Sin = 1'b0;
    logic       Sin_en = 1'b0;
    logic       Pat_load = 1'b0;
    logic [3:0] Pat_in = 4'b0000;
    logic       Cnt_clr = 1'b0;

    logic       out_a, out_b, out_c;
    logic       armed_a, armed_b, armed_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    always #5 clk = ~clk;

    seq_detect_param #(.N(4), .PATTERN(4'b0101), .OVERLAP(1'b1), .CNT_W(8)) u_a (
        .CP(clk), .nCR(nCR), .Sin(Sin), .Sin_en(Sin_en), .Pat_load(Pat_load),
        .Pat_in(Pat_in), .Cnt_clr(Cnt_clr), .Out(out_a), .Match_cnt(cnt_a),
        .Armed(armed_a)
    );

    seq_detect_param #(.N(4), .PATTERN(4'b0101), .OVERLAP(1'b0), .CNT_W(8)) u_b (
        .CP(clk), .nCR(nCR), .Sin(Sin), .Sin_en(Sin_en), .Pat_load(Pat_load),
        .Pat_in(Pat_in), .Cnt_clr(Cnt_clr), .Out(out_b), .Match_cnt(cnt_b),
        .Armed(armed_b)
    );

    seq_detect_param #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u_c (
        .CP(clk), .nCR(nCR), .Sin(Sin), .Sin_en(Sin_en), .Pat_load(Pat_load),
        .Pat_in(Pat_in), .Cnt_clr(Cnt_clr), .Out(out_c), .Match_cnt(cnt_c),
        .Armed(armed_c)
    );

    typedef struct {
        int    dut;
        bit    eo;
        int    ec;
        bit    ea;
        string nm;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push_exp(input int dut, input bit eo, input int ec,
                            input bit ea, input string nm);
        exp_t e;
        e.dut = dut; e.eo = eo; e.ec = ec; e.ea = ea; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic step(input bit s, input bit en, input bit ld, input bit clr,
                        input logic [3:0] pin, input int dut, input bit eo,
                        input int ec, input bit ea, input string nm);
        @(negedge clk);
        Sin = s; Sin_en = en; Pat_load = ld; Cnt_clr = clr; Pat_in = pin;
        push_exp(dut, eo, ec, ea, nm);
    endtask

    // Serial bit on instance dut, no load or clear
    task automatic bit_in(input bit s, input int dut, input bit eo,
                          input int ec, input bit ea, input string nm);
        step(s, 1'b1, 1'b0, 1'b0, 4'b0000, dut, eo, ec, ea, nm);
    endtask

    // Asynchronous reset asserted while the clock is low; optionally check
    // the instance outputs before any clock edge arrives.
    task automatic do_reset(input bit chk, input int dut, input string nm);
        @(negedge clk);
        Sin_en = 1'b0; Pat_load = 1'b0; Cnt_clr = 1'b0;
        if (chk) push_exp(dut, 1'b0, 0, 1'b0, nm);
        nCR = 1'b0;
        @(negedge clk);
        nCR = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        bit   ao, aa;
        int   ac;
        forever begin
            @(posedge clk or negedge nCR);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                case (e.dut)
                    0:       begin ao = out_a; ac = int'(cnt_a); aa = armed_a; end
                    1:       begin ao = out_b; ac = int'(cnt_b); aa = armed_b; end
                    default: begin ao = out_c; ac = int'(cnt_c); aa = armed_c; end
                endcase
                n_checks++;
                if (ao !== e.eo) begin
                    n_fail++;
                    $display("FAIL %s Out: got %0b expected %0b", e.nm, ao, e.eo);
                end
                n_checks++;
                if (ac != e.ec) begin
                    n_fail++;
                    $display("FAIL %s Match_cnt: got %0d expected %0d", e.nm, ac, e.ec);
                end
                n_checks++;
                if (aa !== e.ea) begin
                    n_fail++;
                    $display("FAIL %s Armed: got %0b expected %0b", e.nm, aa, e.ea);
                end
                if (ao === e.eo && ac == e.ec && aa === e.ea)
                    $display("ok   %s dut=%0d Out=%0b cnt=%0d Armed=%0b", e.nm, e.dut, ao, ac, aa);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset state of every instance while nCR is held low
        for (int d = 0; d < 3; d++) begin
            @(negedge clk);
            push_exp(d, 1'b0, 0, 1'b0, "init_reset");
        end
        @(negedge clk);
        nCR = 1'b1;

        // A: overlapping 0101 on 0,1,0,1,0,1
        do_reset(1'b0, 0, "");
        bit_in(1'b0, 0, 1'b0, 0, 1'b0, "ov_b1");
        bit_in(1'b1, 0, 1'b0, 0, 1'b0, "ov_b2");
        bit_in(1'b0, 0, 1'b0, 0, 1'b1, "ov_b3");
        bit_in(1'b1, 0, 1'b1, 1, 1'b1, "ov_b4");
        bit_in(1'b0, 0, 1'b0, 1, 1'b1, "ov_b5");
        bit_in(1'b1, 0, 1'b1, 2, 1'b1, "ov_b6");
        bit_in(1'b0, 0, 1'b0, 2, 1'b1, "ov_b7");
        bit_in(1'b1, 0, 1'b1, 3, 1'b1, "ov_b8");
        bit_in(1'b0, 0, 1'b0, 3, 1'b1, "ov_b9");

        // A: asynchronous reset mid-window, then a fresh window is needed
        do_reset(1'b1, 0, "mid_reset");
        bit_in(1'b1, 0, 1'b0, 0, 1'b0, "rst_b1");
        bit_in(1'b0, 0, 1'b0, 0, 1'b0, "rst_b2");
        bit_in(1'b1, 0, 1'b0, 0, 1'b1, "rst_b3");
        bit_in(1'b0, 0, 1'b0, 0, 1'b1, "rst_b4");
        bit_in(1'b1, 0, 1'b1, 1, 1'b1, "rst_b5");

        // B: non-overlapping 0101 on 0,1,0,1,0,1,0,1
        do_reset(1'b0, 1, "");
        bit_in(1'b0, 1, 1'b0, 0, 1'b0, "nov_b1");
        bit_in(1'b1, 1, 1'b0, 0, 1'b0, "nov_b2");
        bit_in(1'b0, 1, 1'b0, 0, 1'b1, "nov_b3");
        bit_in(1'b1, 1, 1'b1, 1, 1'b0, "nov_b4");
        bit_in(1'b0, 1, 1'b0, 1, 1'b0, "nov_b5");
        bit_in(1'b1, 1, 1'b0, 1, 1'b0, "nov_b6");
        bit_in(1'b0, 1, 1'b0, 1, 1'b1, "nov_b7");
        bit_in(1'b1, 1, 1'b1, 2, 1'b0, "nov_b8");

        // A: Sin_en gap with Sin toggling
        do_reset(1'b0, 0, "");
        bit_in(1'b0, 0, 1'b0, 0, 1'b0, "gap_b1");
        bit_in(1'b1, 0, 1'b0, 0, 1'b0, "gap_b2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 0, 1'b0, "gap_idle1");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 0, 1'b0, "gap_idle2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 0, 1'b0, "gap_idle3");
        bit_in(1'b0, 0, 1'b0, 0, 1'b1, "gap_b3");
        bit_in(1'b1, 0, 1'b1, 1, 1'b1, "gap_b4");

        // A: run-time pattern load 1101
        do_reset(1'b0, 0, "");
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b1101, 0, 1'b0, 0, 1'b0, "load1");
        bit_in(1'b0, 0, 1'b0, 0, 1'b0, "ld_old_b1");
        bit_in(1'b1, 0, 1'b0, 0, 1'b0, "ld_old_b2");
        bit_in(1'b0, 0, 1'b0, 0, 1'b1, "ld_old_b3");
        bit_in(1'b1, 0, 1'b0, 0, 1'b1, "ld_old_b4");
        bit_in(1'b1, 0, 1'b0, 0, 1'b1, "ld_b5");
        bit_in(1'b1, 0, 1'b0, 0, 1'b1, "ld_b6");
        bit_in(1'b0, 0, 1'b0, 0, 1'b1, "ld_b7");
        bit_in(1'b1, 0, 1'b1, 1, 1'b1, "ld_b8");
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b1101, 0, 1'b0, 1, 1'b0, "load2");
        bit_in(1'b1, 0, 1'b0, 1, 1'b0, "ld2_b1");
        bit_in(1'b1, 0, 1'b0, 1, 1'b0, "ld2_b2");
        bit_in(1'b0, 0, 1'b0, 1, 1'b1, "ld2_b3");
        bit_in(1'b1, 0, 1'b1, 2, 1'b1, "ld2_b4");

        // C: all-ones pattern, 2-bit saturating counter, clear behaviour
        do_reset(1'b0, 2, "");
        bit_in(1'b1, 2, 1'b0, 0, 1'b0, "sat_b1");
        bit_in(1'b1, 2, 1'b0, 0, 1'b0, "sat_b2");
        bit_in(1'b1, 2, 1'b0, 0, 1'b1, "sat_b3");
        bit_in(1'b1, 2, 1'b1, 1, 1'b1, "sat_b4");
        bit_in(1'b1, 2, 1'b1, 2, 1'b1, "sat_b5");
        bit_in(1'b1, 2, 1'b1, 3, 1'b1, "sat_b6");
        bit_in(1'b1, 2, 1'b1, 3, 1'b1, "sat_b7");
        bit_in(1'b1, 2, 1'b1, 3, 1'b1, "sat_b8");
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 2, 1'b1, 1, 1'b1, "clr_on_match");
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 2, 1'b0, 0, 1'b1, "clr_alone");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2, 1'b0, 0, 1'b1, "idle_after_clr");

        // Drain the scoreboard with a bounded wait
        @(negedge clk);
        Sin_en = 1'b0; Pat_load = 1'b0; Cnt_clr = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses left, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "time limit");
    end

endmodule
